mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one mem_system (cache + four_bank_mem) between instruction fetch (I) and data (D).
//  Selects one requester and presents its access to mem_system. Holds that access until mem_system Done.
//  Returns Done/DataOut to the winner and stalls the loser.
//  Adds round-robin fairness, a busy watchdog, and a sticky error summary.
// PARAMETERS
//  RR_EN    1    1: round-robin on simultaneous requests; 0: D always wins
//  TIMEOUT  64   max cycles in a BUSY state before the watchdog fires (>=2; counter width $clog2(TIMEOUT+1))
// PORTS
//  clk         in   1   system clock
//  rst         in   1   synchronous, active-high reset
//  i_rd        in   1   I read request; held until i_done
//  i_addr      in   16  I address
//  i_data_out  out  16  read data to I; valid only when i_done=1, else 0
//  i_done      out  1   I access complete (single-cycle pulse)
//  i_stall     out  1   I requesting and not done this cycle
//  d_rd        in   1   D read request
//  d_wr        in   1   D write request
//  d_addr      in   16  D address
//  d_data_in   in   16  D write data
//  d_data_out  out  16  read data to D; valid only when d_done=1, else 0
//  d_done      out  1   D access complete (single-cycle pulse)
//  d_stall     out  1   D requesting and not done this cycle
//  m_addr      out  16  to mem_system Addr
//  m_data_in   out  16  to mem_system DataIn
//  m_rd        out  1   to mem_system Rd
//  m_wr        out  1   to mem_system Wr
//  m_data_out  in   16  from mem_system DataOut
//  m_done      in   1   from mem_system Done
//  m_err       in   1   from mem_system err
//  err         out  1   sticky error: m_err | watchdog | d_rd&d_wr; cleared only by rst
// BEHAVIOUR
//  States: IDLE, BUSY_I, BUSY_D. rr_ptr: 0 = D has priority next, 1 = I has priority next.
//  Reset values: state=IDLE, rr_ptr=0, wdog=0, err=0.
//  Outputs immediately after reset: m_rd=m_wr=0, all done/stall=0, data outs=0.
//  IDLE: choose the winner combinationally.
//   - Only one requester active: that requester wins.
//   - Both active: rr_ptr selects the winner (RR_EN=0: D wins).
//   - The winner's addr/data/op drive m_* in the same cycle; the winner's addr/data/op are latched into hold registers.
//   - m_done in the same cycle (cache hit): x_done=1, x_data_out=m_data_out, stay in IDLE.
//   - Otherwise go to BUSY_x.
//  BUSY_x: m_* come only from the hold registers. Requester input changes are ignored.
//   - On m_done: x_done=1, x_data_out=m_data_out, next state IDLE.
//   - The next arbitration happens in IDLE on the following cycle, combinationally. Back-to-back accesses therefore have zero bubble.
//  rr_ptr update: on every completed access, rr_ptr <= (winner==D). Update only if RR_EN=1.
//  x_stall = x_req & ~x_done.
//   - The non-owner is stalled for the whole access.
//   - The owner stalls every cycle until its done cycle.
//  d_rd & d_wr together is illegal: err <= 1; D is not granted; d_stall=1.
//  Watchdog:
//   - wdog counts cycles in BUSY_x and clears on entry to IDLE.
//   - When wdog reaches TIMEOUT: err <= 1 and the FSM returns to IDLE. The owner gets no done.
//  m_err=1 in any cycle sets err. Arbitration continues normally.
//  A requester that drops its request while BUSY still receives x_done when the access completes.
//  Reset mid-access: everything returns to reset values on the next edge and m_rd/m_wr drop. mem_system is reset by the same rst.
// TESTING
//  1. Lone I read of 0x0010 that hits (m_done in the same cycle) -> m_rd=1, m_addr=0x0010 that cycle; i_done=1, i_data_out=m_data_out; i_stall=0; stays in IDLE.
//  2. I and D (write 0x0200=0xBEEF) request together after reset.
//     -> D wins (rr_ptr=0); i_stall=1 throughout; d_done on m_done.
//     -> The next cycle grants I at 0x0010 with no idle bubble.
//  3. Both requesters active continuously for 6 accesses (RR_EN=1) -> grants alternate D,I,D,I,D,I. With RR_EN=0 -> D starves I (6 D grants).
//  4. D miss in BUSY_D; d_addr changes to 0x1234 mid-access -> m_addr stays at the original latched address until m_done.
//  5. m_done held low for TIMEOUT=64 cycles in BUSY_D -> err=1 at cycle 64; FSM returns to IDLE; no d_done; err stays 1 until rst.
//  6. d_rd=d_wr=1 -> err=1, m_rd=m_wr=0, d_stall=1. Then rst pulse mid-BUSY_I -> next cycle: IDLE, err=0, all outputs 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester-side (I/D) and mem_system-side signals of the memory arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface mem_arbiter_if;
    logic        i_rd;
    logic [15:0] i_addr;
    logic [15:0] i_data_out;
    logic        i_done;
    logic        i_stall;
    logic        d_rd;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_data_in;
    logic [15:0] d_data_out;
    logic        d_done;
    logic        d_stall;
    logic [15:0] m_addr;
    logic [15:0] m_data_in;
    logic        m_rd;
    logic        m_wr;
    logic [15:0] m_data_out;
    logic        m_done;
    logic        m_err;
    logic        err;

    modport slave (
        input  i_rd, i_addr, d_rd, d_wr, d_addr, d_data_in, m_data_out, m_done, m_err,
        output i_data_out, i_done, i_stall, d_data_out, d_done, d_stall,
               m_addr, m_data_in, m_rd, m_wr, err
    );

    modport master (
        output i_rd, i_addr, d_rd, d_wr, d_addr, d_data_in, m_data_out, m_done, m_err,
        input  i_data_out, i_done, i_stall, d_data_out, d_done, d_stall,
               m_addr, m_data_in, m_rd, m_wr, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one mem_system between instruction fetch and data ports, with
// round-robin fairness, a busy watchdog and a sticky error flag.
module mem_arbiter #(
    parameter int unsigned RR_EN   = 1,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_I = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;

    logic [1:0]     state_q, state_d;
    logic           rr_q, rr_d;
    logic [WDW-1:0] wdog_q, wdog_d;
    logic           err_q, err_d;
    logic [15:0]    hold_addr_q, hold_addr_d;
    logic [15:0]    hold_data_q, hold_data_d;
    logic           hold_wr_q, hold_wr_d;

    logic        d_illegal, d_req, d_ok, pick_d, pick_i;
    logic        i_done_c, d_done_c, m_rd_c, m_wr_c;
    logic [15:0] m_addr_c, m_data_in_c;

    assign d_illegal = bus.d_rd & bus.d_wr;
    assign d_req     = bus.d_rd | bus.d_wr;
    assign d_ok      = bus.d_rd ^ bus.d_wr;
    // rr_q=1 hands priority to I on a tie; without round-robin D always wins
    assign pick_d    = d_ok & (~bus.i_rd | (RR_EN == 0) | ~rr_q);
    assign pick_i    = bus.i_rd & ~pick_d;

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        wdog_d      = '0;
        err_d       = err_q | bus.m_err | d_illegal;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        hold_wr_d   = hold_wr_q;
        i_done_c    = 1'b0;
        d_done_c    = 1'b0;
        m_rd_c      = 1'b0;
        m_wr_c      = 1'b0;
        m_addr_c    = '0;
        m_data_in_c = '0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_d) begin
                        m_addr_c    = bus.d_addr;
                        m_data_in_c = bus.d_data_in;
                        m_rd_c      = bus.d_rd;
                        m_wr_c      = bus.d_wr;
                        hold_addr_d = bus.d_addr;
                        hold_data_d = bus.d_data_in;
                        hold_wr_d   = bus.d_wr;
                        if (bus.m_done) begin
                            d_done_c = 1'b1;
                            if (RR_EN != 0) rr_d = 1'b1;
                        end else begin
                            state_d = ST_BUSY_D;
                        end
                    end else if (pick_i) begin
                        m_addr_c    = bus.i_addr;
                        m_rd_c      = 1'b1;
                        hold_addr_d = bus.i_addr;
                        hold_data_d = '0;
                        hold_wr_d   = 1'b0;
                        if (bus.m_done) begin
                            i_done_c = 1'b1;
                            if (RR_EN != 0) rr_d = 1'b0;
                        end else begin
                            state_d = ST_BUSY_I;
                        end
                    end
                end
                ST_BUSY_I, ST_BUSY_D: begin
                    m_addr_c    = hold_addr_q;
                    m_data_in_c = hold_data_q;
                    m_rd_c      = ~hold_wr_q;
                    m_wr_c      = hold_wr_q;
                    if (bus.m_done) begin
                        state_d = ST_IDLE;
                        if (state_q == ST_BUSY_D) d_done_c = 1'b1;
                        else                      i_done_c = 1'b1;
                        if (RR_EN != 0) rr_d = (state_q == ST_BUSY_D);
                    end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                        // abandon the access; owner gets no done
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        wdog_d = wdog_q + WDW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_q        <= 1'b0;
            wdog_q      <= '0;
            err_q       <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            hold_wr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            wdog_q      <= wdog_d;
            err_q       <= err_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            hold_wr_q   <= hold_wr_d;
        end
    end

    assign bus.m_addr     = m_addr_c;
    assign bus.m_data_in  = m_data_in_c;
    assign bus.m_rd       = m_rd_c;
    assign bus.m_wr       = m_wr_c;
    assign bus.i_done     = i_done_c;
    assign bus.d_done     = d_done_c;
    assign bus.i_data_out = i_done_c ? bus.m_data_out : 16'h0000;
    assign bus.d_data_out = d_done_c ? bus.m_data_out : 16'h0000;
    assign bus.i_stall    = bus.i_rd & ~i_done_c;
    assign bus.d_stall    = d_req & ~d_done_c;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle-by-cycle vector table plus
// hand-written sequences for fairness, hold, watchdog and reset.
module tb_mem_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mem_arbiter_if bus1 ();
    mem_arbiter_if bus0 ();

    mem_arbiter #(.RR_EN(1), .TIMEOUT(64)) dut_rr (.clk(clk), .rst(rst), .bus(bus1.slave));
    mem_arbiter #(.RR_EN(0), .TIMEOUT(64)) dut_fx (.clk(clk), .rst(rst), .bus(bus0.slave));

    assign bus0.i_rd       = bus1.i_rd;
    assign bus0.i_addr     = bus1.i_addr;
    assign bus0.d_rd       = bus1.d_rd;
    assign bus0.d_wr       = bus1.d_wr;
    assign bus0.d_addr     = bus1.d_addr;
    assign bus0.d_data_in  = bus1.d_data_in;
    assign bus0.m_data_out = bus1.m_data_out;
    assign bus0.m_done     = bus1.m_done;
    assign bus0.m_err      = bus1.m_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        i_rd;
        logic [15:0] i_addr;
        logic        d_rd, d_wr;
        logic [15:0] d_addr, d_data_in, m_data_out;
        logic        m_done, m_err;
        logic        e_m_rd, e_m_wr;
        logic [15:0] e_m_addr, e_m_data_in;
        logic        e_i_done;
        logic [15:0] e_i_data;
        logic        e_i_stall, e_d_done;
        logic [15:0] e_d_data;
        logic        e_d_stall, e_err;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(
        input logic ir, input logic [15:0] ia, input logic dr, input logic dw,
        input logic [15:0] da, input logic [15:0] dd, input logic [15:0] mo,
        input logic md, input logic me,
        input logic emr, input logic emw, input logic [15:0] ema, input logic [15:0] emd,
        input logic eid, input logic [15:0] eida, input logic eis,
        input logic edd, input logic [15:0] edda, input logic eds, input logic eer);
        vec_t v;
        v.i_rd = ir; v.i_addr = ia; v.d_rd = dr; v.d_wr = dw; v.d_addr = da;
        v.d_data_in = dd; v.m_data_out = mo; v.m_done = md; v.m_err = me;
        v.e_m_rd = emr; v.e_m_wr = emw; v.e_m_addr = ema; v.e_m_data_in = emd;
        v.e_i_done = eid; v.e_i_data = eida; v.e_i_stall = eis;
        v.e_d_done = edd; v.e_d_data = edda; v.e_d_stall = eds; v.e_err = eer;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ir, input logic [15:0] ia, input logic dr, input logic dw,
                         input logic [15:0] da, input logic [15:0] dd, input logic [15:0] mo,
                         input logic md, input logic me);
        bus1.i_rd = ir; bus1.i_addr = ia; bus1.d_rd = dr; bus1.d_wr = dw;
        bus1.d_addr = da; bus1.d_data_in = dd; bus1.m_data_out = mo;
        bus1.m_done = md; bus1.m_err = me;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        //         ir ia       dr dw da       dd       mo       md me  mr mw ma       mdi      id idat     is dd ddat     ds er
        vecs[0]  = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 0);
        vecs[1]  = mk(1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 16'h1111, 1, 0, 1, 0, 16'h0010, 16'h0000, 1, 16'h1111, 0, 0, 16'h0000, 0, 0);
        vecs[2]  = mk(1, 16'h0010, 0, 1, 16'h0200, 16'hBEEF, 16'h0000, 0, 0, 0, 1, 16'h0200, 16'hBEEF, 0, 16'h0000, 1, 0, 16'h0000, 1, 0);
        vecs[3]  = mk(1, 16'h0010, 0, 1, 16'h0200, 16'hBEEF, 16'h0000, 0, 0, 0, 1, 16'h0200, 16'hBEEF, 0, 16'h0000, 1, 0, 16'h0000, 1, 0);
        vecs[4]  = mk(1, 16'h0010, 0, 1, 16'h0200, 16'hBEEF, 16'h5555, 1, 0, 0, 1, 16'h0200, 16'hBEEF, 0, 16'h0000, 1, 1, 16'h5555, 0, 0);
        vecs[5]  = mk(1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h0010, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 0, 0);
        vecs[6]  = mk(1, 16'h0099, 1, 0, 16'h0300, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h0010, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 1, 0);
        vecs[7]  = mk(1, 16'h0099, 1, 0, 16'h0300, 16'h0000, 16'hA5A5, 1, 0, 1, 0, 16'h0010, 16'h0000, 1, 16'hA5A5, 0, 0, 16'h0000, 1, 0);
        vecs[8]  = mk(0, 16'h0000, 1, 0, 16'h0300, 16'h0000, 16'h0F0F, 1, 0, 1, 0, 16'h0300, 16'h0000, 0, 16'h0000, 0, 1, 16'h0F0F, 0, 0);
        vecs[9]  = mk(1, 16'h0020, 1, 0, 16'h0300, 16'h0000, 16'h1234, 1, 0, 1, 0, 16'h0020, 16'h0000, 1, 16'h1234, 0, 0, 16'h0000, 1, 0);
        vecs[10] = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 0);
        vecs[11] = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 1);
        vecs[12] = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h9999, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 1);

        do_reset();
        for (int k = 0; k < 13; k++) begin
            drive(vecs[k].i_rd, vecs[k].i_addr, vecs[k].d_rd, vecs[k].d_wr, vecs[k].d_addr,
                  vecs[k].d_data_in, vecs[k].m_data_out, vecs[k].m_done, vecs[k].m_err);
            #2;
            chk($sformatf("v%0d m_rd", k),       32'(bus1.m_rd),       32'(vecs[k].e_m_rd));
            chk($sformatf("v%0d m_wr", k),       32'(bus1.m_wr),       32'(vecs[k].e_m_wr));
            chk($sformatf("v%0d m_addr", k),     32'(bus1.m_addr),     32'(vecs[k].e_m_addr));
            chk($sformatf("v%0d m_data_in", k),  32'(bus1.m_data_in),  32'(vecs[k].e_m_data_in));
            chk($sformatf("v%0d i_done", k),     32'(bus1.i_done),     32'(vecs[k].e_i_done));
            chk($sformatf("v%0d i_data_out", k), 32'(bus1.i_data_out), 32'(vecs[k].e_i_data));
            chk($sformatf("v%0d i_stall", k),    32'(bus1.i_stall),    32'(vecs[k].e_i_stall));
            chk($sformatf("v%0d d_done", k),     32'(bus1.d_done),     32'(vecs[k].e_d_done));
            chk($sformatf("v%0d d_data_out", k), 32'(bus1.d_data_out), 32'(vecs[k].e_d_data));
            chk($sformatf("v%0d d_stall", k),    32'(bus1.d_stall),    32'(vecs[k].e_d_stall));
            chk($sformatf("v%0d err", k),        32'(bus1.err),        32'(vecs[k].e_err));
            tick();
        end

        // fairness: both request every cycle, every access hits
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(1, 16'h0010, 1, 0, 16'h0200, 16'h0000, 16'(16'h7000 + k), 1, 0);
            #2;
            chk($sformatf("rr%0d m_addr", k),  32'(bus1.m_addr), (k % 2 == 0) ? 32'h0200 : 32'h0010);
            chk($sformatf("rr%0d i_done", k),  32'(bus1.i_done), (k % 2 == 0) ? 32'd0 : 32'd1);
            chk($sformatf("fix%0d m_addr", k), 32'(bus0.m_addr), 32'h0200);
            chk($sformatf("fix%0d i_stall", k), 32'(bus0.i_stall), 32'd1);
            tick();
        end

        // latched address survives requester changes
        do_reset();
        drive(0, 16'h0, 1, 0, 16'h0400, 16'h0, 16'h0, 0, 0);
        #2;
        chk("hold grant m_addr", 32'(bus1.m_addr), 32'h0400);
        tick();
        bus1.d_addr = 16'h1234;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk($sformatf("hold%0d m_addr", k), 32'(bus1.m_addr), 32'h0400);
            chk($sformatf("hold%0d d_stall", k), 32'(bus1.d_stall), 32'd1);
            tick();
        end
        bus1.m_done = 1'b1; bus1.m_data_out = 16'hCAFE;
        #2;
        chk("hold done d_done", 32'(bus1.d_done), 32'd1);
        chk("hold done d_data_out", 32'(bus1.d_data_out), 32'hCAFE);
        chk("hold done m_addr", 32'(bus1.m_addr), 32'h0400);
        tick();

        // watchdog: 64 busy cycles without m_done
        do_reset();
        drive(0, 16'h0, 0, 1, 16'h0500, 16'h0042, 16'h0, 0, 0);
        #2;
        chk("wdog grant m_addr", 32'(bus1.m_addr), 32'h0500);
        tick();
        bus1.d_addr = 16'h0600;
        for (int k = 1; k <= 63; k++) begin
            #2;
            chk($sformatf("wdog%0d d_done", k), 32'(bus1.d_done), 32'd0);
            tick();
        end
        chk("wdog err before", 32'(bus1.err), 32'd0);
        #2;
        chk("wdog last m_addr", 32'(bus1.m_addr), 32'h0500);
        chk("wdog last d_done", 32'(bus1.d_done), 32'd0);
        tick();
        chk("wdog err fired", 32'(bus1.err), 32'd1);
        #2;
        chk("wdog idle regrant m_addr", 32'(bus1.m_addr), 32'h0600);
        drive(0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0);
        tick(); tick(); tick();
        chk("wdog err sticky", 32'(bus1.err), 32'd1);

        // illegal D op, then reset in the middle of a BUSY_I access
        do_reset();
        drive(0, 16'h0, 1, 1, 16'h0700, 16'h0, 16'h0, 0, 0);
        #2;
        chk("illegal m_rd", 32'(bus1.m_rd), 32'd0);
        chk("illegal m_wr", 32'(bus1.m_wr), 32'd0);
        chk("illegal d_stall", 32'(bus1.d_stall), 32'd1);
        chk("illegal d_done", 32'(bus1.d_done), 32'd0);
        tick();
        chk("illegal err", 32'(bus1.err), 32'd1);
        drive(1, 16'h0010, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0);
        tick();
        #2;
        chk("busy_i m_rd", 32'(bus1.m_rd), 32'd1);
        chk("busy_i m_addr", 32'(bus1.m_addr), 32'h0010);
        rst = 1'b1;
        bus1.i_rd = 1'b0;
        #1;
        chk("rst m_rd drop", 32'(bus1.m_rd), 32'd0);
        tick();
        rst = 1'b0;
        #2;
        chk("post-rst err", 32'(bus1.err), 32'd0);
        chk("post-rst m_rd", 32'(bus1.m_rd), 32'd0);
        chk("post-rst m_wr", 32'(bus1.m_wr), 32'd0);
        chk("post-rst m_addr", 32'(bus1.m_addr), 32'h0000);
        chk("post-rst i_stall", 32'(bus1.i_stall), 32'd0);
        chk("post-rst i_done", 32'(bus1.i_done), 32'd0);
        bus1.i_rd = 1'b1; bus1.i_addr = 16'h0030;
        #1;
        chk("post-rst idle grant m_addr", 32'(bus1.m_addr), 32'h0030);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
